// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: engine states, ALU opcodes and the
// two ALU operations the MAC datapath uses.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALUOP_SUM = 4'b0100;
  localparam logic [3:0] ALUOP_MUL = 4'b0110;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } alu_out_t;

  // Wrapped 32-bit result plus a flag that the true signed result did not fit.
  function automatic alu_out_t alu_calc(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] sum;
    alu_out_t    r;
    r    = '0;
    // Low 64 bits of the sign-extended product equal the exact signed product.
    prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    sum  = a + b;
    case (op)
      ALUOP_MUL: begin
        r.res = prod[31:0];
        r.ovf = (prod[63:31] != {33{prod[31]}});
      end
      ALUOP_SUM: begin
        r.res = sum;
        r.ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: total_result = op1*op2 + op3, wrapped,
// with separate overflow flags for the multiply and the add.
module mac_unit
  import mac_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] op3,
  output logic [31:0] total_result,
  output logic        ovf_mul,
  output logic        ovf_add
);

  alu_out_t mul_out;
  alu_out_t add_out;

  // Product first, then the wrapped product is added to the accumulator input.
  always_comb begin
    mul_out      = alu_calc(ALUOP_MUL, op1, op2);
    add_out      = alu_calc(ALUOP_SUM, mul_out.res, op3);
    total_result = add_out.res;
    ovf_mul      = mul_out.ovf;
    ovf_add      = add_out.ovf;
  end

endmodule

// File: rtl/dot_product_engine.sv
// Streams operand pairs through mac_unit and reports one signed dot product
// per run, starting from a bias, with sticky overflow and a zero flag.
//
//  state | meaning
//  IDLE  | waiting for start; captures bias/len/clears sticky flag
//  ACC   | accepting one pair per handshake, counting down remaining elements
//  DONE  | result presented until the consumer takes it
module dot_product_engine
  import mac_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [31:0]      acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf_st;
  logic [31:0]      mac_total;
  logic             ovf_mul;
  logic             ovf_add;
  logic             in_hs;

  mac_unit u_mac (
    .op1          (in_a),
    .op2          (in_b),
    .op3          (acc),
    .total_result (mac_total),
    .ovf_mul      (ovf_mul),
    .ovf_add      (ovf_add)
  );

  assign in_hs = (state == ACC) && in_valid;

  // State register plus accumulator, element counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf_st <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= bias;
            cnt    <= len;
            ovf_st <= 1'b0;
          end
        end
        ACC: begin
          if (in_hs) begin
            acc    <= mac_total;
            ovf_st <= ovf_st | ovf_mul | ovf_add;
            cnt    <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len != '0) ? ACC : DONE;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == LEN_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign result = acc;
  assign ovf    = ovf_st;
  assign zero   = (state == DONE) && (acc == '0);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with hand-computed expectations.
module tb_dot_product_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] va[4];
  logic [31:0] vb[4];

  dot_product_engine #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full run with continuous in_valid using pairs from va/vb.
  task automatic do_run(input string tag, input logic [7:0] n, input logic [31:0] b0,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_zero);
    int   lat;
    int   idx;
    logic saw_rdy;
    logic hs;
    start = 1'b1;
    len   = n;
    bias  = b0;
    cyc();
    start   = 1'b0;
    lat     = 1;
    idx     = 0;
    saw_rdy = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) saw_rdy = 1'b1;
      in_valid = (idx < int'(n)) && (idx < 4);
      in_a     = (idx < 4) ? va[idx] : 32'd0;
      in_b     = (idx < 4) ? vb[idx] : 32'd0;
      hs       = in_valid && in_ready;
      cyc();
      if (hs) idx++;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_rdy_seen"}, {31'd0, saw_rdy}, {31'd0, (n != 8'd0)});
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_ov"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 10 + 6 + 20 - 6 = 30
    va = '{32'd2, 32'd4, 32'hFFFF_FFFF, 32'd0};
    vb = '{32'd3, 32'd5, 32'd6, 32'd0};
    do_run("len3", 8'd3, 32'd10, 4, 32'd30, 1'b0, 1'b0);

    do_run("len0", 8'd0, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF9, 1'b0, 1'b0);

    // 2^16 * 2^16 = 2^32 wraps to 0
    va = '{32'h0001_0000, 32'd0, 32'd0, 32'd0};
    vb = '{32'h0001_0000, 32'd0, 32'd0, 32'd0};
    do_run("mulovf", 8'd1, 32'd0, 2, 32'd0, 1'b1, 1'b1);

    va = '{32'd1, 32'd0, 32'd0, 32'd0};
    vb = '{32'd1, 32'd0, 32'd0, 32'd0};
    do_run("addovf", 8'd1, 32'h7FFF_FFFF, 2, 32'h8000_0000, 1'b1, 1'b0);

    // Backpressure with gaps and ignored start pulses.
    start = 1'b1; len = 8'd2; bias = 32'd0;
    cyc();
    start = 1'b0;
    chk("bp_acc_ready", {31'd0, in_ready}, 32'd1);
    start = 1'b1; len = 8'd0; bias = 32'd77;
    cyc();
    start = 1'b0;
    cyc();
    chk("bp_gap_result", result, 32'd0);
    chk("bp_gap_busy", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd3;
    cyc();
    in_valid = 1'b0;
    chk("bp_first_acc", result, 32'd9);
    cyc(); cyc();
    chk("bp_hold_acc", result, 32'd9);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_done_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_done_result", result, 32'd10);
      chk("bp_done_ready", {31'd0, in_ready}, 32'd0);
      start = (i == 1); bias = 32'd55; len = 8'd0;
      in_valid = 1'b1;
      cyc();
      start = 1'b0; in_valid = 1'b0;
    end
    chk("bp_final_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_final_result", result, 32'd10);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    cyc();
    chk("bp_no_restart", {31'd0, out_valid | busy}, 32'd0);

    // Reset mid-run after two accepted pairs.
    start = 1'b1; len = 8'd4; bias = 32'd100;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'hFFFF_FFF0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_ovf", {31'd0, ovf}, 32'd0);
    cyc();
    chk("mrst_still_idle", {31'd0, busy}, 32'd0);

    va = '{32'd2, 32'd0, 32'd0, 32'd0};
    vb = '{32'd2, 32'd0, 32'd0, 32'd0};
    do_run("fresh", 8'd1, 32'd5, 2, 32'd9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
